// File: rtl/lfsr_pkg.sv
// Shared Galois LFSR helpers: state typedef, standard PRBS feedback masks and
// a width-generic stepping function used by the combinational LFSR core.
package lfsr_pkg;

  localparam int MAX_DEG = 64;
  localparam int MAX_KS  = 64;

  // States are indexed [DEGREE:1]; narrower LFSRs sit zero-extended in this type.
  typedef logic [MAX_DEG:1] lfsr_state_t;

  localparam logic [7:1]  PRBS7  = 7'b110_0000;
  localparam logic [15:1] PRBS15 = 15'b110_0000_0000_0000;
  localparam logic [31:1] PRBS31 = 31'h4800_0000;

  typedef struct packed {
    lfsr_state_t       state;
    logic [MAX_KS-1:0] ks;
  } galois_res_t;

  // Upper (unused) state bits stay zero because the mask is zero there too.
  function automatic galois_res_t galois_step(input lfsr_state_t state,
                                              input lfsr_state_t poly,
                                              input int          n);
    galois_res_t r;
    lfsr_state_t s;
    r = '0;
    s = state;
    for (int i = 0; i < MAX_KS; i++) begin
      if (i < n) begin
        r.ks[i] = s[1];
        s = {1'b0, s[MAX_DEG:2]};
        if (r.ks[i]) s = s ^ poly;
      end
    end
    r.state = s;
    return r;
  endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Combinational Galois LFSR core: OUTPUT_WIDTH steps from the given state,
// returning the LSB-first keystream and the advanced state.
module lfsr_galois
  import lfsr_pkg::*;
#(
  parameter int                     POLY_DEGREE  = 7,
  parameter logic [POLY_DEGREE:1]   POLYNOMIAL   = PRBS7,
  parameter int                     OUTPUT_WIDTH = 8
) (
  input  logic [POLY_DEGREE:1]  state,
  output logic [OUTPUT_WIDTH-1:0] ks,
  output logic [POLY_DEGREE:1]  state_next
);

  lfsr_state_t state_ext;
  lfsr_state_t poly_ext;
  galois_res_t res;
  logic        unused_res;

  always_comb begin
    state_ext                = '0;
    state_ext[POLY_DEGREE:1] = state;
    poly_ext                 = '0;
    poly_ext[POLY_DEGREE:1]  = POLYNOMIAL;
    res = galois_step(state_ext, poly_ext, OUTPUT_WIDTH);
  end

  assign ks         = res.ks[OUTPUT_WIDTH-1:0];
  assign state_next = res.state[POLY_DEGREE:1];
  assign unused_res = ^res;

endmodule

// File: rtl/lfsr_galois_scrambler.sv
// Additive stream scrambler/descrambler: registered Galois LFSR feeding a
// single-register valid/ready output slice, with seed load and frame reseed.
module lfsr_galois_scrambler
  import lfsr_pkg::*;
#(
  parameter int                   POLY_DEGREE    = 7,
  parameter logic [POLY_DEGREE:1] POLYNOMIAL     = PRBS7,
  parameter int                   DATA_WIDTH     = 8,
  parameter logic [POLY_DEGREE:1] SEED           = '1,
  parameter bit                   RESEED_ON_LAST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   seed_valid,
  input  logic [POLY_DEGREE:1]   seed,
  input  logic                   bypass,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [DATA_WIDTH-1:0]  s_tdata,
  input  logic                   s_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [DATA_WIDTH-1:0]  m_tdata,
  output logic                   m_tlast,
  output logic [POLY_DEGREE:1]   state_out,
  output logic                   seed_err
);

  logic [POLY_DEGREE:1]  state_q;
  logic [POLY_DEGREE:1]  seed_reg;
  logic [POLY_DEGREE:1]  state_adv;
  logic [DATA_WIDTH-1:0] ks;
  logic                  accept;

  lfsr_galois #(
    .POLY_DEGREE (POLY_DEGREE),
    .POLYNOMIAL  (POLYNOMIAL),
    .OUTPUT_WIDTH(DATA_WIDTH)
  ) u_core (
    .state      (state_q),
    .ks         (ks),
    .state_next (state_adv)
  );

  // Seed load takes the cycle so it never races a data beat for the state.
  assign s_tready  = !rst && !seed_valid && (!m_tvalid || m_tready);
  assign accept    = s_tvalid && s_tready;
  assign state_out = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEED;
      seed_reg <= SEED;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
      seed_err <= 1'b0;
    end else begin
      seed_err <= 1'b0;
      if (seed_valid) begin
        if (seed != '0) begin
          seed_reg <= seed;
          state_q  <= seed;
        end else begin
          seed_err <= 1'b1;
        end
      end
      if (accept) begin
        m_tdata  <= bypass ? s_tdata : (s_tdata ^ ks);
        m_tlast  <= s_tlast;
        m_tvalid <= 1'b1;
        if (s_tlast && RESEED_ON_LAST) state_q <= seed_reg;
        else if (!bypass)               state_q <= state_adv;
      end else if (m_tvalid && m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_galois_scrambler.sv
// Directed scoreboard bench: expected beats queued at issue, popped by
// negedge monitors on the scrambler and on a chained descrambler.
module tb_lfsr_galois_scrambler;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       seed_valid = 1'b0;
  logic [7:1] seed = '0;
  logic       bypass = 1'b0;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic [7:0] s_tdata = '0;
  logic       s_tlast = 1'b0;
  logic       m_tvalid;
  logic       tb_m_tready = 1'b1;
  logic       m_tready;
  logic [7:0] m_tdata;
  logic       m_tlast;
  logic [7:1] state_out;
  logic       seed_err;

  logic       chain = 1'b0;
  logic       d_s_tvalid, d_s_tready, d_m_tvalid, d_m_tlast, d_seed_err;
  logic [7:0] d_m_tdata;
  logic [7:1] d_state_out;

  int errors = 0;
  int checks = 0;
  beat_t q[$];
  beat_t q2[$];

  always #5 clk = ~clk;

  assign m_tready   = chain ? d_s_tready : tb_m_tready;
  assign d_s_tvalid = chain && m_tvalid;

  lfsr_galois_scrambler dut (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed), .bypass(bypass),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .state_out(state_out), .seed_err(seed_err)
  );

  lfsr_galois_scrambler u_descr (
    .clk(clk), .rst(rst), .seed_valid(1'b0), .seed(7'h00), .bypass(1'b0),
    .s_tvalid(d_s_tvalid), .s_tready(d_s_tready), .s_tdata(m_tdata), .s_tlast(m_tlast),
    .m_tvalid(d_m_tvalid), .m_tready(1'b1), .m_tdata(d_m_tdata), .m_tlast(d_m_tlast),
    .state_out(d_state_out), .seed_err(d_seed_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Monitors: a beat transfers at the posedge following a negedge with valid&ready.
  always @(negedge clk) begin
    beat_t e;
    if (!rst && !chain && m_tvalid && m_tready) begin
      if (q.size() == 0) chk("unexpected_beat", {m_tlast, m_tdata}, 32'hDEAD);
      else begin
        e = q.pop_front();
        chk("scr_data", m_tdata, e.data);
        chk("scr_last", m_tlast, e.last);
      end
    end
    if (!rst && chain && d_m_tvalid) begin
      if (q2.size() == 0) chk("unexpected_rt_beat", {d_m_tlast, d_m_tdata}, 32'hDEAD);
      else begin
        e = q2.pop_front();
        chk("rt_data", d_m_tdata, e.data);
        chk("rt_last", d_m_tlast, e.last);
      end
    end
    if (!rst && state_out == 7'h00) chk("state_nonzero", state_out, 32'h1);
  end

  task automatic expect_beat(input logic [7:0] d, input logic l);
    q.push_back('{data: d, last: l});
  endtask

  // Presents a beat and returns #1 after the accepting edge.
  task automatic send(input logic [7:0] d, input logic l);
    logic acc;
    int   n;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = s_tready;
      n++;
      @(posedge clk);
    end
    #1;
    s_tvalid = 1'b0;
    if (!acc) chk("send_timeout", 32'h0, 32'h1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    logic [7:0] rd;
    logic       rl;
    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("s_tready_in_rst", s_tready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_state", state_out, 7'h7F);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_m_tdata", m_tdata, 8'h00);
    chk("rst_seed_err", seed_err, 1'b0);

    // Basic keystream, 3-beat frame, then reseeded new frame
    expect_beat(8'h3F, 1'b0); send(8'h00, 1'b0);
    chk("lat_m_tvalid", m_tvalid, 1'b1);
    chk("state_1", state_out, 7'h10);
    expect_beat(8'h10, 1'b0); send(8'h00, 1'b0);
    chk("state_2", state_out, 7'h0C);
    expect_beat(8'h0C, 1'b1); send(8'h00, 1'b1);
    chk("state_reseed", state_out, 7'h7F);
    expect_beat(8'h3F, 1'b0); send(8'h00, 1'b0);
    chk("state_newframe", state_out, 7'h10);

    // Backpressure
    idle();
    tb_m_tready = 1'b0;
    expect_beat(8'hB5, 1'b0); send(8'hA5, 1'b0);
    chk("bp_state0", state_out, 7'h0C);
    s_tvalid = 1'b1; s_tdata = 8'h00; s_tlast = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_s_tready", s_tready, 1'b0);
      chk("bp_m_tdata", m_tdata, 8'hB5);
      chk("bp_state", state_out, 7'h0C);
    end
    @(posedge clk); #1;
    tb_m_tready = 1'b1;
    expect_beat(8'h0C, 1'b1); send(8'h00, 1'b1);
    chk("bp_release_state", state_out, 7'h7F);

    // Bypass: data passes, state holds, reseed on last still applies
    expect_beat(8'h3F, 1'b0); send(8'h00, 1'b0);
    bypass = 1'b1;
    expect_beat(8'h5A, 1'b0); send(8'h5A, 1'b0);
    chk("byp_state_hold", state_out, 7'h10);
    bypass = 1'b0;
    expect_beat(8'h10, 1'b0); send(8'h00, 1'b0);
    bypass = 1'b1;
    expect_beat(8'h77, 1'b1); send(8'h77, 1'b1);
    chk("byp_reseed", state_out, 7'h7F);
    bypass = 1'b0;

    // Seed load: zero rejected, then 7'h10 accepted
    seed_valid = 1'b1; seed = 7'h00;
    @(negedge clk);
    chk("seed_s_tready", s_tready, 1'b0);
    @(posedge clk); #1;
    seed_valid = 1'b0;
    chk("seed_err_pulse", seed_err, 1'b1);
    chk("seed0_state", state_out, 7'h7F);
    idle();
    chk("seed_err_clear", seed_err, 1'b0);
    seed_valid = 1'b1; seed = 7'h10;
    idle();
    seed_valid = 1'b0;
    chk("seed_load_state", state_out, 7'h10);
    chk("seed_ok_no_err", seed_err, 1'b0);
    expect_beat(8'h10, 1'b0); send(8'h00, 1'b0);
    expect_beat(8'h0C, 1'b1); send(8'h00, 1'b1);
    chk("seed_reg_reseed", state_out, 7'h10);

    // Reset mid-frame with a held output beat
    idle();
    tb_m_tready = 1'b0;
    send(8'h00, 1'b0);
    chk("pre_rst_m_tvalid", m_tvalid, 1'b1);
    chk("pre_rst_m_tdata", m_tdata, 8'h10);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_m_tvalid", m_tvalid, 1'b0);
    chk("midrst_state", state_out, 7'h7F);
    chk("midrst_m_tdata", m_tdata, 8'h00);
    chk("midrst_m_tlast", m_tlast, 1'b0);
    rst = 1'b0;
    tb_m_tready = 1'b1;

    // Round trip through a second instance with the same seed
    chain = 1'b1;
    for (int i = 0; i < 64; i++) begin
      rd = 8'($urandom);
      rl = (i % 8 == 7);
      q2.push_back('{data: rd, last: rl});
      send(rd, rl);
    end
    n = 0;
    while (q2.size() != 0 && n < 50) begin idle(); n++; end
    chk("rt_drained", q2.size(), 0);
    chk("scr_drained", q.size(), 0);
    chain = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1);
  end

endmodule
